io_pattern_tester: RTL

Parametrised successor to the board bring-up IO toggler. It drives CH_NUM external IO pins with one of four selectable test patterns: alternating, walking-one, binary count, or PRBS shift. Patterns advance on a programmable tick. Two raw board keys are debounced internally; one cycles the mode, the other toggles pause. The block sits in the board-test top, between the keys/LEDs and the expansion headers.

---
 rtl/io_pattern_tester_if.sv | 22 ++
 rtl/io_pattern_tester.sv | 118 +++++++++++
 2 files changed

// File: rtl/io_pattern_tester_if.sv
// Key inputs and pattern/status outputs of io_pattern_tester.
// The master side is the board/bench, and the slave side is the tester block.
interface io_pattern_tester_if #(
  parameter int CH_NUM = 34
);
  logic              i_key_mode;
  logic              i_key_pause;
  logic [CH_NUM-1:0] o_io;
  logic [1:0]        o_mode;
  logic              o_paused;
  logic              o_tick;

  modport master (
    output i_key_mode, i_key_pause,
    input  o_io, o_mode, o_paused, o_tick
  );

  modport slave (
    input  i_key_mode, i_key_pause,
    output o_io, o_mode, o_paused, o_tick
  );
endinterface

// File: rtl/io_pattern_tester.sv
// Drives CH_NUM IO pins with ALT / WALK / COUNT / PRBS7 patterns advancing on a prescaled tick.
// Two debounced active-low keys are used: one cycles the mode, and the other toggles pause.
module io_pattern_tester #(
  parameter int CH_NUM     = 34,
  parameter int TICK_DIV   = 25000000,
  parameter int DEB_CYCLES = 1000000
) (
  input logic              i_clk,
  input logic              i_rst,
  io_pattern_tester_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    MODE_ALT   = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  // Index 0 is the mode key, and index 1 is the pause key.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, deb, deb_d;
  logic [DW-1:0] cnt [2];
  logic [1:0]    press;

  mode_e             mode;
  mode_e             next_mode;
  logic [CH_NUM-1:0] io;
  logic              paused;
  logic              tick;
  logic [PW-1:0]     presc;
  logic [6:0]        lfsr;
  logic              nb;

  function automatic logic [CH_NUM-1:0] seed_of(input mode_e m);
    logic [CH_NUM-1:0] s;
    s = '0;
    case (m)
      MODE_ALT:  for (int unsigned i = 1; i < unsigned'(CH_NUM); i += 2) s[i] = 1'b1;
      MODE_WALK: s[0] = 1'b1;
      default:   s = '0;
    endcase
    return s;
  endfunction

  assign raw       = {bus.i_key_pause, bus.i_key_mode};
  assign press     = deb_d & ~deb;
  assign nb        = lfsr[6] ^ lfsr[5];
  assign next_mode = mode_e'(mode + 2'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      for (int unsigned k = 0; k < 2; k++) cnt[k] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned k = 0; k < 2; k++) begin
        if (sync2[k] == deb[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == DW'(DEB_CYCLES - 1)) begin
          deb[k] <= sync2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // A mode press takes priority over a coincident tick, so the new seed is never advanced in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      io     <= seed_of(MODE_ALT);
      mode   <= MODE_ALT;
      paused <= 1'b0;
      tick   <= 1'b0;
      presc  <= '0;
      lfsr   <= 7'h7F;
    end else begin
      tick <= 1'b0;
      if (press[1]) paused <= ~paused;
      if (press[0]) begin
        mode  <= next_mode;
        io    <= seed_of(next_mode);
        presc <= '0;
        lfsr  <= 7'h7F;
      end else if (!paused) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc <= '0;
          tick  <= 1'b1;
          case (mode)
            MODE_ALT:   io <= ~io;
            MODE_WALK:  io <= {io[CH_NUM-2:0], io[CH_NUM-1]};
            MODE_COUNT: io <= io + 1'b1;
            MODE_PRBS: begin
              lfsr <= {lfsr[5:0], nb};
              io   <= {io[CH_NUM-2:0], nb};
            end
          endcase
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign bus.o_io     = io;
  assign bus.o_mode   = mode;
  assign bus.o_paused = paused;
  assign bus.o_tick   = tick;
endmodule
